mac_dot_sequencer: RTL and testbench
====================================

// Module: mac_dot_sequencer
// PURPOSE
//  Sequences one mac instance to compute dot products of two Nbits operand vectors held in a
//  dual-output operand RAM (1-cycle read latency). On start, it clears the MAC, streams vec_len
//  operand pairs into it, waits out the pipeline, then holds the 2*Nbits result on a valid/ready port.
//  Sits between the matrix-level control FSM and the MAC/RAM datapath.
// PARAMETERS
//  Nbits  4  operand width; result/accumulator width is 2*Nbits (matches mac)
//  LEN_W  4  width of vec_len and rd_addr; max vector length 2**LEN_W-1
// PORTS
//  clk              in   1        clock
//  reset            in   1        synchronous, active-high reset
//  start            in   1        job request; sampled only in IDLE
//  vec_len          in   LEN_W    number of operand pairs; latched when start is accepted
//  busy             out  1        high in every state except IDLE
//  rd_en            out  1        operand RAM read enable
//  rd_addr          out  LEN_W    operand RAM address; a_data/b_data valid one cycle later
//  a_data           in   Nbits    RAM output A
//  b_data           in   Nbits    RAM output B
//  mac_clear        out  1        drives mac reset input
//  mac_multiplier   out  Nbits    to mac multiplier
//  mac_multiplicand out  Nbits    to mac multiplicand
//  mac_acc          in   2*Nbits  mac accumulator_out
//  result           out  2*Nbits  dot-product result, stable while result_valid
//  result_valid     out  1        result available
//  result_ready     in   1        consumer accepts result
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, rd_en=0, rd_addr=0, result=0, result_valid=0, internal data-valid flag=0.
//  States: IDLE -> CLEAR -> RUN -> DRAIN -> RESULT -> IDLE.
//  - IDLE: mac_clear=1, operands forced 0. start=1 -> CLEAR, latch vec_len, idx=0.
//  - CLEAR: one cycle, mac_clear=1. vec_len==0 -> DRAIN, otherwise -> RUN.
//  - RUN: rd_en=1, rd_addr=idx, idx++ each cycle. At idx==len-1 -> DRAIN (exactly len reads).
//  - DRAIN: exactly 2 cycles, rd_en=0. On the last DRAIN edge, result <= mac_acc. -> RESULT.
//  - RESULT: result_valid=1, result held. result_valid && result_ready -> IDLE (valid drops next cycle).
//  Operand gating: dv <= rd_en, registered. mac_multiplier/multiplicand = dv ? a_data/b_data : 0,
//   so the mac adds 0 in every non-data cycle. mac_clear is combinational from state (IDLE|CLEAR).
//  Latency: start sampled at edge T0 -> result_valid high from cycle T0+len+4 (len=0: T0+4).
//  Arithmetic: products and sum wrap modulo 2**(2*Nbits), with no saturation.
//   Overflow is not flagged unless MAC_SEQ_PERF_EN is defined (see CONFIGURATION).
//  start while busy: ignored, not queued. start held high across RESULT->IDLE: a new job starts
//   on the first IDLE edge.
//  result_ready while not valid: ignored. vec_len changes after acceptance: no effect.
//  Reset mid-job: back to IDLE next edge, in-flight data discarded. The mac is cleared by mac_clear
//   in IDLE. No partial result is presented.
// CONFIGURATION
//  MAC_SEQ_PERF_EN defined: adds outputs job_count (16b, +1 per accepted result handshake, wraps)
//   and ovf (1b, sticky per job; set if any accumulation carry-out is detected
//   (mac_acc_next < mac_acc) during dv cycles; cleared in CLEAR; valid with result).
//   Both counters reset to 0.
//  Not defined: these ports and logic are absent; all other behaviour is identical.
// TESTING (Nbits=4, LEN_W=4)
//  1. A=[1,2,3], B=[4,5,6], len=3, ready=1 -> rd_addr 0,1,2; result=32 (0x20), valid at T0+7, 1 cycle.
//  2. len=1, A=[7], B=[3] -> result=21 (0x15) at T0+5; back-to-back start -> second result correct
//     (clear verified).
//  3. len=2, A=[15,15], B=[15,15] -> result=194 (0xC2, wrapped); with MAC_SEQ_PERF_EN, ovf=1.
//  4. result_ready low 3 cycles in RESULT, start pulsed -> result/valid stable, start ignored,
//     single handshake.
//  5. reset asserted in RUN at idx=2 of len=5 -> next cycle IDLE, busy=0, valid=0; a new len=3 job
//     of scenario 1 gives 32.
//  6. len=0 -> no rd_en pulses; result=0, valid at T0+4; with MAC_SEQ_PERF_EN, job_count increments.

Source files
------------

// File: rtl/mac_dot_sequencer.sv
// Sequences one external MAC through a dot product of two operand vectors read from a dual-output RAM.
// Latency: a start accepted at edge T0 raises o_result_valid after edge T0+vec_len+3, so edge T0+vec_len+4 is the first to sample it high.
// Backpressure: the result is held on o_result/o_result_valid until i_result_ready; i_start is ignored while busy.
//
// Parameters: Nbits (operand width, result is 2*Nbits), LEN_W (vec_len / rd_addr width).
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_start, i_vec_len             job request (sampled in IDLE) and number of operand pairs
//   o_busy                         high in every state except IDLE
//   o_rd_en, o_rd_addr             operand RAM read port; i_a_data/i_b_data valid one cycle later
//   i_a_data, i_b_data             operand RAM outputs
//   o_mac_clear                    MAC reset, asserted in IDLE and CLEAR
//   o_mac_multiplier/multiplicand  gated MAC operands (zero outside data cycles)
//   i_mac_acc                      MAC accumulator output
//   o_result, o_result_valid, i_result_ready   result valid/ready port
// Optional build macro MAC_SEQ_PERF_EN adds o_job_count (completed handshakes) and o_ovf
// (sticky per-job accumulator carry-out flag).
module mac_dot_sequencer #(
    parameter int Nbits = 4,
    parameter int LEN_W = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [LEN_W-1:0]   i_vec_len,
    output logic               o_busy,
    output logic               o_rd_en,
    output logic [LEN_W-1:0]   o_rd_addr,
    input  logic [Nbits-1:0]   i_a_data,
    input  logic [Nbits-1:0]   i_b_data,
    output logic               o_mac_clear,
    output logic [Nbits-1:0]   o_mac_multiplier,
    output logic [Nbits-1:0]   o_mac_multiplicand,
    input  logic [2*Nbits-1:0] i_mac_acc,
    output logic [2*Nbits-1:0] o_result,
    output logic               o_result_valid,
    input  logic               i_result_ready
`ifdef MAC_SEQ_PERF_EN
    ,
    output logic [15:0]        o_job_count,
    output logic               o_ovf
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_RESULT
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_idx;
    logic                r_drain;     // 0 in first DRAIN cycle, 1 in second
    logic                r_dv;        // RAM outputs carry a requested operand pair this cycle
    logic [2*Nbits-1:0]  r_result;

    logic                w_last_rd;
    logic                w_handshake;

    assign w_last_rd   = (r_idx == (r_len - {{(LEN_W-1){1'b0}}, 1'b1}));
    assign w_handshake = (r_state == S_RESULT) && i_result_ready;

    assign o_rd_addr          = r_idx;
    assign o_result           = r_result;
    // Non-data cycles feed zeros so the MAC accumulates nothing.
    assign o_mac_multiplier   = r_dv ? i_a_data : '0;
    assign o_mac_multiplicand = r_dv ? i_b_data : '0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        o_busy         = 1'b1;
        o_rd_en        = 1'b0;
        o_mac_clear    = 1'b0;
        o_result_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy      = 1'b0;
                o_mac_clear = 1'b1;
                if (i_start) begin
                    w_next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                o_mac_clear  = 1'b1;
                w_next_state = (r_len == '0) ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
                o_rd_en = 1'b1;
                if (w_last_rd) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Two cycles: RAM read latency plus the MAC accumulate register.
                if (r_drain) begin
                    w_next_state = S_RESULT;
                end
            end
            S_RESULT: begin
                o_result_valid = 1'b1;
                if (i_result_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_len    <= '0;
            r_idx    <= '0;
            r_drain  <= 1'b0;
            r_dv     <= 1'b0;
            r_result <= '0;
        end else begin
            r_dv <= o_rd_en;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_len <= i_vec_len;
                        r_idx <= '0;
                    end
                end
                S_CLEAR: begin
                    r_drain <= 1'b0;
                end
                S_RUN: begin
                    r_idx <= r_idx + {{(LEN_W-1){1'b0}}, 1'b1};
                end
                S_DRAIN: begin
                    r_drain <= 1'b1;
                    if (r_drain) begin
                        r_result <= i_mac_acc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MAC_SEQ_PERF_EN
    logic [15:0]        r_job_count;
    logic               r_ovf;
    logic [2*Nbits-1:0] w_product;
    logic [2*Nbits-1:0] w_acc_next;

    // Mirror of the MAC's next accumulator value; a wrap shows up as next < current.
    assign w_product  = {{Nbits{1'b0}}, o_mac_multiplier} * {{Nbits{1'b0}}, o_mac_multiplicand};
    assign w_acc_next = i_mac_acc + w_product;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_job_count <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_handshake) begin
                r_job_count <= r_job_count + 16'd1;
            end
            if (r_state == S_CLEAR) begin
                r_ovf <= 1'b0;
            end else if (r_dv && (w_acc_next < i_mac_acc)) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_job_count = r_job_count;
    assign o_ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Testbench for mac_dot_sequencer: models the operand RAM and the MAC around the DUT.
// Latency: jobs are checked against first-sampled-valid edge T0+len+4.
// Backpressure: result_ready is held low for a per-job number of cycles before the handshake.
module tb_mac_dot_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] vec_len;
    logic       busy;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [3:0] a_data = 4'd0;
    logic [3:0] b_data = 4'd0;
    logic       mac_clear;
    logic [3:0] mac_multiplier;
    logic [3:0] mac_multiplicand;
    logic [7:0] mac_acc = 8'd0;
    logic [7:0] result;
    logic       result_valid;
    logic       result_ready;
`ifdef MAC_SEQ_PERF_EN
    logic [15:0] job_count;
    logic        ovf;
    int          jobs_done = 0;
`endif

    mac_dot_sequencer #(.Nbits(4), .LEN_W(4)) dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_start            (start),
        .i_vec_len          (vec_len),
        .o_busy             (busy),
        .o_rd_en            (rd_en),
        .o_rd_addr          (rd_addr),
        .i_a_data           (a_data),
        .i_b_data           (b_data),
        .o_mac_clear        (mac_clear),
        .o_mac_multiplier   (mac_multiplier),
        .o_mac_multiplicand (mac_multiplicand),
        .i_mac_acc          (mac_acc),
        .o_result           (result),
        .o_result_valid     (result_valid),
        .i_result_ready     (result_ready)
`ifdef MAC_SEQ_PERF_EN
        ,
        .o_job_count        (job_count),
        .o_ovf              (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Operand RAM, 1-cycle read latency.
    logic [3:0] mem_a [16];
    logic [3:0] mem_b [16];
    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= mem_a[rd_addr];
            b_data <= mem_b[rd_addr];
        end
    end

    // Single-register MAC: accumulator cleared while mac_clear is high.
    always @(posedge clk) begin
        if (mac_clear) mac_acc <= 8'd0;
        else           mac_acc <= mac_acc + ({4'd0, mac_multiplier} * {4'd0, mac_multiplicand});
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: unwrapped dot product of the first len nibble pairs.
    function automatic int ref_sum(input int len, input logic [59:0] a, input logic [59:0] b);
        int s = 0;
        for (int i = 0; i < len; i++) s += int'(a[i*4 +: 4]) * int'(b[i*4 +: 4]);
        return s;
    endfunction

    typedef struct {
        int          len;
        logic [59:0] a;      // nibble i = element i
        logic [59:0] b;
        int          dly;    // cycles result_ready stays low while valid
        int          sum;    // expected unwrapped dot product
    } vec_t;

    function automatic vec_t mkv(input int len, input logic [59:0] a, input logic [59:0] b,
                                 input int dly, input int sum);
        vec_t v;
        v.len = len; v.a = a; v.b = b; v.dly = dly; v.sum = sum;
        return v;
    endfunction

    task automatic run_job(input string tag, input vec_t v);
        int  nrd = 0;
        int  lat = 0;
        bit  got = 0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = (i < 15) ? v.a[i*4 +: 4] : 4'd0;
            mem_b[i] = (i < 15) ? v.b[i*4 +: 4] : 4'd0;
        end
        start        = 1'b1;
        vec_len      = 4'(v.len);
        result_ready = 1'b0;
        @(posedge clk);                       // edge T0: start accepted
        #1;
        start   = 1'b0;
        vec_len = 4'($urandom);               // must not affect the running job
        chk({tag, " busy"}, 32'(busy), 32'd1);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (rd_en) begin
                chk({tag, " rd_addr"}, 32'(rd_addr), 32'(nrd));
                nrd++;
            end
            if (result_valid) begin
                lat = k + 1;                  // next edge is the first to sample valid high
                got = 1;
                break;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(v.len + 4));
        chk({tag, " reads"}, 32'(nrd), 32'(v.len));
        chk({tag, " result"}, 32'(result), 32'(v.sum % 256));
`ifdef MAC_SEQ_PERF_EN
        chk({tag, " ovf"}, 32'(ovf), 32'(v.sum >= 256));
`endif
        if (got) begin
            for (int d = 0; d < v.dly; d++) begin
                start = (d == 1);             // pulse start while stalled in RESULT
                @(posedge clk);
                #1;
                chk({tag, " valid hold"}, 32'(result_valid), 32'd1);
                chk({tag, " result hold"}, 32'(result), 32'(v.sum % 256));
            end
            start        = 1'b0;
            result_ready = 1'b1;
            @(posedge clk);
            #1;
            result_ready = 1'b0;
            chk({tag, " valid drop"}, 32'(result_valid), 32'd0);
            chk({tag, " idle"}, 32'(busy), 32'd0);
`ifdef MAC_SEQ_PERF_EN
            jobs_done++;
            chk({tag, " job_count"}, 32'(job_count), 32'(jobs_done));
`endif
            if (v.dly > 1) begin
                @(posedge clk);
                #1;
                chk({tag, " start not queued"}, 32'(busy), 32'd0);
            end
        end
    endtask

    vec_t tbl [7];

    initial begin
        // 1*4+2*5+3*6=32; 7*3=21; 2*225=450 (wraps to 194); 2*4+3*5=23; 15*225=3375 (wraps to 47)
        tbl[0] = mkv(3,  60'h321,  60'h654,  0, 32);
        tbl[1] = mkv(1,  60'h7,    60'h3,    0, 21);
        tbl[2] = mkv(2,  60'h32,   60'h54,   0, 23);    // back-to-back after tbl[1]: MAC cleared
        tbl[3] = mkv(2,  60'hFF,   60'hFF,   0, 450);
        tbl[4] = mkv(3,  60'h321,  60'h654,  3, 32);    // ready low 3 cycles, start pulsed
        tbl[5] = mkv(0,  60'h9,    60'h9,    0, 0);
        tbl[6] = mkv(15, {15{4'hF}}, {15{4'hF}}, 1, 3375);

        reset        = 1'b1;
        start        = 1'b0;
        vec_len      = 4'd0;
        result_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 4'd0;
            mem_b[i] = 4'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset rd_en", 32'(rd_en), 32'd0);
        chk("reset rd_addr", 32'(rd_addr), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset valid", 32'(result_valid), 32'd0);
        chk("reset mac_clear", 32'(mac_clear), 32'd1);
        chk("reset operands", 32'({mac_multiplier, mac_multiplicand}), 32'd0);
`ifdef MAC_SEQ_PERF_EN
        chk("reset job_count", 32'(job_count), 32'd0);
        chk("reset ovf", 32'(ovf), 32'd0);
`endif
        reset = 1'b0;

        for (int t = 0; t < 7; t++) run_job($sformatf("tbl%0d", t), tbl[t]);

        // Reset while reading index 2 of a 5-element job.
        begin
            bit hit = 0;
            @(negedge clk);
            for (int i = 0; i < 16; i++) begin
                mem_a[i] = 4'd9;
                mem_b[i] = 4'd9;
            end
            start   = 1'b1;
            vec_len = 4'd5;
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (rd_en && rd_addr == 4'd2) begin
                    hit = 1;
                    break;
                end
                @(posedge clk);
                #1;
            end
            chk("midreset reached idx2", 32'(hit), 32'd1);
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            chk("midreset busy", 32'(busy), 32'd0);
            chk("midreset valid", 32'(result_valid), 32'd0);
            chk("midreset rd_en", 32'(rd_en), 32'd0);
            run_job("after reset", tbl[0]);
        end

        // Random jobs against the reference model.
        for (int r = 0; r < 20; r++) begin
            vec_t v;
            v.len = int'($urandom_range(0, 15));
            v.a   = 60'({$urandom(), $urandom()});
            v.b   = 60'({$urandom(), $urandom()});
            v.dly = int'($urandom_range(0, 2));
            v.sum = ref_sum(v.len, v.a, v.b);
            run_job($sformatf("rand%0d", r), v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
